// File: rtl/i_memory_access.sv
`timescale 1ns/1ps
// i_memory_access: MEM stage of the RV32I pipeline.
// Performs byte/half/word loads and stores against a local word-organised
// data memory and registers the writeback payload into the MEM/WB boundary.
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   i_valid, i_stall        slot valid, hold MEM/WB and suppress writes
//   i_ctrl_*                memory/writeback control from EX/MEM
//   i_IE_result             ALU result (byte address for loads/stores)
//   i_IE_data_write         store data (rs2)
//   i_IE_rd_addr            destination register
//   o_valid, o_MEM_result, o_MEM_rd_addr, o_ctrl_reg_write, o_mem_misaligned
//                           registered MEM/WB payload
module i_memory_access #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_DEPTH      = 256,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_valid,
   input  logic                      i_stall,
   input  logic                      i_ctrl_mem_write,
   input  logic                      i_ctrl_mem_read,
   input  logic [1:0]                i_ctrl_mem_size,
   input  logic                      i_ctrl_mem_unsigned,
   input  logic                      i_ctrl_result_src,
   input  logic                      i_ctrl_reg_write,
   input  logic [DATA_WIDTH-1:0]     i_IE_result,
   input  logic [DATA_WIDTH-1:0]     i_IE_data_write,
   input  logic [REG_ADDR_WIDTH-1:0] i_IE_rd_addr,
   output logic                      o_valid,
   output logic [DATA_WIDTH-1:0]     o_MEM_result,
   output logic [REG_ADDR_WIDTH-1:0] o_MEM_rd_addr,
   output logic                      o_ctrl_reg_write,
   output logic                      o_mem_misaligned
);

   localparam int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);
   localparam int unsigned LANES          = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
   logic [MEM_ADDR_WIDTH-1:0] word_idx;
   logic [1:0]                byte_off;
   logic [DATA_WIDTH-1:0]     rd_word;
   logic [7:0]                byte_sel;
   logic [15:0]               half_sel;
   logic                      mis;
   logic                      mem_access;
   logic                      mem_we;
   logic [DATA_WIDTH-1:0]     load_data;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [LANES-1:0]          be;
   logic                      unused_addr_bits;

   // Upper address bits are dropped so accesses wrap around the array.
   assign word_idx         = i_IE_result[MEM_ADDR_WIDTH+1:2];
   assign byte_off         = i_IE_result[1:0];
   assign unused_addr_bits = ^i_IE_result[DATA_WIDTH-1:MEM_ADDR_WIDTH+2];

   // Alignment check; size 11 is always treated as a fault.
   always_comb begin
      mis = 1'b0;
      case (i_ctrl_mem_size)
         2'b00:   mis = 1'b0;
         2'b01:   mis = byte_off[0];
         2'b10:   mis = (byte_off != 2'b00);
         default: mis = 1'b1;
      endcase
   end

   assign mem_access = i_ctrl_mem_read | i_ctrl_mem_write;
   assign mem_we     = i_valid & i_ctrl_mem_write & ~mis & ~i_stall & i_reset_n;

   // Combinational read: pre-store contents even when a store is in flight.
   assign rd_word  = mem[word_idx];
   assign byte_sel = rd_word[{byte_off, 3'b000} +: 8];
   assign half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

   // Lane select and sign/zero extension; faulted accesses return 0.
   always_comb begin
      load_data = '0;
      if (!mis) begin
         case (i_ctrl_mem_size)
            2'b00:   load_data = i_ctrl_mem_unsigned ? DATA_WIDTH'(byte_sel)
                                 : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            2'b01:   load_data = i_ctrl_mem_unsigned ? DATA_WIDTH'(half_sel)
                                 : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            default: load_data = rd_word;
         endcase
      end
   end

   // Store data is replicated across lanes; byte enables pick the target lanes.
   always_comb begin
      wdata = i_IE_data_write;
      be    = '0;
      case (i_ctrl_mem_size)
         2'b00: begin
            wdata = {LANES{i_IE_data_write[7:0]}};
            be    = LANES'(1) << byte_off;
         end
         2'b01: begin
            wdata = {(LANES/2){i_IE_data_write[15:0]}};
            be    = byte_off[1] ? 4'b1100 : 4'b0011;
         end
         2'b10:   be = '1;
         default: be = '0;
      endcase
   end

   // Data memory write port; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (be[i]) mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // MEM/WB boundary registers; reset takes priority over stall.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_valid          <= 1'b0;
         o_MEM_result     <= '0;
         o_MEM_rd_addr    <= '0;
         o_ctrl_reg_write <= 1'b0;
         o_mem_misaligned <= 1'b0;
      end else if (!i_stall) begin
         o_valid          <= i_valid;
         o_MEM_result     <= i_ctrl_result_src ? load_data : i_IE_result;
         o_MEM_rd_addr    <= i_IE_rd_addr;
         o_ctrl_reg_write <= i_valid & i_ctrl_reg_write & ~(mis & mem_access);
         o_mem_misaligned <= i_valid & mem_access & mis;
      end
   end

endmodule

// File: tb/tb_i_memory_access.sv
`timescale 1ns/1ps
// Directed bench for the MEM stage: table of single-cycle vectors followed by
// hand-written stall and reset sequences.
module tb_i_memory_access;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid, stall, wr, rd, uns, src, rw;
   logic [1:0]  size;
   logic [31:0] addr, wdat;
   logic [4:0]  rd_addr;
   logic        o_valid, o_rw, o_mis;
   logic [31:0] o_res;
   logic [4:0]  o_rd;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   i_memory_access dut (
      .i_clk               (clk),
      .i_reset_n           (reset_n),
      .i_valid             (valid),
      .i_stall             (stall),
      .i_ctrl_mem_write    (wr),
      .i_ctrl_mem_read     (rd),
      .i_ctrl_mem_size     (size),
      .i_ctrl_mem_unsigned (uns),
      .i_ctrl_result_src   (src),
      .i_ctrl_reg_write    (rw),
      .i_IE_result         (addr),
      .i_IE_data_write     (wdat),
      .i_IE_rd_addr        (rd_addr),
      .o_valid             (o_valid),
      .o_MEM_result        (o_res),
      .o_MEM_rd_addr       (o_rd),
      .o_ctrl_reg_write    (o_rw),
      .o_mem_misaligned    (o_mis)
   );

   typedef struct {
      logic        valid, wr, rd, uns, src, rw;
      logic [1:0]  size;
      logic [31:0] addr, data;
      logic [31:0] e_res;
      logic        e_rw, e_mis;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic w, logic r, logic [1:0] sz, logic u,
                               logic s, logic rwe, logic [31:0] a, logic [31:0] d,
                               logic [31:0] er, logic erw, logic emis);
      vec_t t;
      t.valid = v; t.wr = w; t.rd = r; t.size = sz; t.uns = u; t.src = s; t.rw = rwe;
      t.addr = a; t.data = d; t.e_res = er; t.e_rw = erw; t.e_mis = emis;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic r, input logic [1:0] sz,
                        input logic u, input logic s, input logic rwe,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rda);
      valid = v; wr = w; rd = r; size = sz; uns = u; src = s; rw = rwe;
      addr = a; wdat = d; rd_addr = rda;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [31:0] res, input logic v,
                          input logic rwe, input logic mis, input logic [4:0] rda);
      chk({name, ".result"}, o_res, res);
      chk({name, ".valid"}, 32'(o_valid), 32'(v));
      chk({name, ".reg_write"}, 32'(o_rw), 32'(rwe));
      chk({name, ".misaligned"}, 32'(o_mis), 32'(mis));
      chk({name, ".rd_addr"}, 32'(o_rd), 32'(rda));
   endtask

   initial begin
      // valid, wr, rd, size, uns, src, rw, addr, data, exp_result, exp_rw, exp_mis
      vecs.push_back(mk(1,1,0,2'b10,0,0,0,32'h10, 32'hDEADBEEF, 32'h10,       0,0)); // SW
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h10, 32'h0,        32'hDEADBEEF, 1,0)); // LW
      vecs.push_back(mk(1,1,0,2'b10,0,0,0,32'h04, 32'h0,        32'h04,       0,0)); // SW 0
      vecs.push_back(mk(1,1,0,2'b00,0,0,0,32'h05, 32'h123456AB, 32'h05,       0,0)); // SB
      vecs.push_back(mk(1,0,1,2'b00,0,1,1,32'h05, 32'h0,        32'hFFFFFFAB, 1,0)); // LB
      vecs.push_back(mk(1,0,1,2'b00,1,1,1,32'h05, 32'h0,        32'h000000AB, 1,0)); // LBU
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h04, 32'h0,        32'h0000AB00, 1,0)); // LW
      vecs.push_back(mk(1,1,0,2'b01,0,0,0,32'h06, 32'hFFFF8001, 32'h06,       0,0)); // SH
      vecs.push_back(mk(1,0,1,2'b01,0,1,1,32'h06, 32'h0,        32'hFFFF8001, 1,0)); // LH
      vecs.push_back(mk(1,0,1,2'b01,1,1,1,32'h06, 32'h0,        32'h00008001, 1,0)); // LHU
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h04, 32'h0,        32'h8001AB00, 1,0)); // LW
      vecs.push_back(mk(1,0,1,2'b00,0,1,1,32'h07, 32'h0,        32'hFFFFFF80, 1,0)); // LB top
      vecs.push_back(mk(1,0,1,2'b00,1,1,1,32'h04, 32'h0,        32'h00000000, 1,0)); // LBU
      vecs.push_back(mk(1,1,0,2'b10,0,0,0,32'h00, 32'h11223344, 32'h00,       0,0)); // SW
      vecs.push_back(mk(1,1,0,2'b01,0,0,1,32'h03, 32'h00005566, 32'h03,       0,1)); // SH mis
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h00, 32'h0,        32'h11223344, 1,0)); // LW
      vecs.push_back(mk(1,0,1,2'b01,0,1,1,32'h01, 32'h0,        32'h0,        0,1)); // LH mis
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h02, 32'h0,        32'h0,        0,1)); // LW mis
      vecs.push_back(mk(1,0,1,2'b11,0,1,1,32'h00, 32'h0,        32'h0,        0,1)); // size 11
      vecs.push_back(mk(0,1,0,2'b10,0,0,1,32'h00, 32'h0,        32'h0,        0,0)); // invalid
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h00, 32'h0,        32'h11223344, 1,0)); // LW
      vecs.push_back(mk(1,0,0,2'b10,0,0,1,32'hCAFEBABE,32'h0,   32'hCAFEBABE, 1,0)); // ALU
      vecs.push_back(mk(1,1,0,2'b10,0,0,0,32'h408,32'h0BADF00D, 32'h408,      0,0)); // wrap SW
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h08, 32'h0,        32'h0BADF00D, 1,0)); // LW
      vecs.push_back(mk(1,1,1,2'b10,0,1,1,32'h10, 32'h55555555, 32'hDEADBEEF, 1,0)); // rd+wr
      vecs.push_back(mk(1,0,1,2'b10,0,1,1,32'h10, 32'h0,        32'h55555555, 1,0)); // LW

      // Reset with a live store on the inputs: outputs must come up cleared.
      reset_n = 1'b0;
      stall   = 1'b0;
      drive(1,1,0,2'b10,0,0,1,32'h30,32'hFFFFFFFF,5'd9);
      tick();
      tick();
      chk_all("reset", 32'h0, 0, 0, 0, 5'd0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].uns,
               vecs[i].src, vecs[i].rw, vecs[i].addr, vecs[i].data, 5'(i));
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].valid,
                 vecs[i].e_rw, vecs[i].e_mis, 5'(i));
      end

      // Stall: outputs hold the prior ALU op and the stalled store does not land.
      drive(1,1,0,2'b10,0,0,0,32'h24,32'h0,5'd1);
      tick();
      drive(1,0,0,2'b10,0,0,1,32'h12345678,32'h0,5'd7);
      tick();
      stall = 1'b1;
      drive(1,1,0,2'b10,0,0,0,32'h24,32'h99999999,5'd9);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_all($sformatf("stall%0d", c), 32'h12345678, 1, 1, 0, 5'd7);
      end
      stall = 1'b0;
      drive(1,1,0,2'b10,0,0,0,32'h20,32'h77777777,5'd2);
      tick();
      chk_all("stall_release", 32'h20, 1, 0, 0, 5'd2);
      drive(1,0,1,2'b10,0,1,1,32'h24,32'h0,5'd3);
      tick();
      chk_all("stall_nowrite", 32'h0, 1, 1, 0, 5'd3);
      drive(1,0,1,2'b10,0,1,1,32'h20,32'h0,5'd4);
      tick();
      chk_all("stall_write", 32'h77777777, 1, 1, 0, 5'd4);

      // Reset mid-store (also with stall high): cleared outputs, no write.
      reset_n = 1'b0;
      stall   = 1'b1;
      drive(1,1,0,2'b10,0,0,1,32'h20,32'hAAAAAAAA,5'd5);
      tick();
      chk_all("reset_mid", 32'h0, 0, 0, 0, 5'd0);
      reset_n = 1'b1;
      stall   = 1'b0;
      drive(1,0,1,2'b10,0,1,1,32'h20,32'h0,5'd6);
      tick();
      chk_all("reset_keep", 32'h77777777, 1, 1, 0, 5'd6);
      drive(1,0,1,2'b10,0,1,1,32'h10,32'h0,5'd8);
      tick();
      chk_all("reset_keep2", 32'h55555555, 1, 1, 0, 5'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
